// File: rtl/ars_pkg.sv
// Shared types and helpers for the GF(2^m) operand select/swap stage.
// Holds the field width, a clog2 helper and the occupancy state encoding.
package ars_pkg;

    localparam int FIELD_W = 233;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/ars_sel_swap_if.sv
// Valid/ready bundle between the register file side and the select/swap stage.
// The master drives requests and OUT_READY; the slave is the stage itself.
interface ars_sel_swap_if
    import ars_pkg::*;
#(
    parameter int WIDTH  = FIELD_W,
    parameter int NUM_IN = 4
);

    localparam int IDX_W = clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] IN_DATA;
    logic [IDX_W-1:0]        IN_SEL_X;
    logic [IDX_W-1:0]        IN_SEL_Y;
    logic                    IN_SWAP;
    logic                    IN_VALID;
    logic                    IN_READY;
    logic [WIDTH-1:0]        OUT_X;
    logic [WIDTH-1:0]        OUT_Y;
    logic                    OUT_ERR;
    logic                    OUT_VALID;
    logic                    OUT_READY;

    modport master (
        output IN_DATA, IN_SEL_X, IN_SEL_Y, IN_SWAP, IN_VALID, OUT_READY,
        input  IN_READY, OUT_X, OUT_Y, OUT_ERR, OUT_VALID
    );

    modport slave (
        input  IN_DATA, IN_SEL_X, IN_SEL_Y, IN_SWAP, IN_VALID, OUT_READY,
        output IN_READY, OUT_X, OUT_Y, OUT_ERR, OUT_VALID
    );

endinterface

// File: rtl/ars_sel_mux.sv
// NUM_IN:1 field-element mux; an index with no matching operand yields
// all-zero data and raises err instead of reading past the packed input.
module ars_sel_mux
    import ars_pkg::*;
#(
    parameter int WIDTH  = FIELD_W,
    parameter int NUM_IN = 4,
    parameter int IDX_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] data,
    input  logic [IDX_W-1:0]        sel,
    output logic [WIDTH-1:0]        q,
    output logic                    err
);

    // Compare against every legal index so out-of-range falls through to zero.
    always_comb begin
        q   = '0;
        err = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == IDX_W'(k)) begin
                q   = data[k*WIDTH +: WIDTH];
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ars_sel_swap.sv
// Registered operand select with constant-time conditional swap, feeding the
// field multiplier/adder through a two-entry (main + skid) valid/ready stage.
module ars_sel_swap
    import ars_pkg::*;
#(
    parameter int WIDTH  = FIELD_W,
    parameter int NUM_IN = 4
) (
    input  logic           CLK,
    input  logic           RST,
    ars_sel_swap_if.slave  bus
);

    localparam int IDX_W = clog2(NUM_IN);

    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic             err_x;
    logic             err_y;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] new_x;
    logic [WIDTH-1:0] new_y;
    logic             new_err;

    occ_t             state;
    occ_t             state_n;
    logic             in_ready;
    logic             accept;
    logic             xfer;
    logic             load_in;
    logic             load_skid;
    logic             load_pop;

    logic [WIDTH-1:0] main_x;
    logic [WIDTH-1:0] main_y;
    logic             main_err;
    logic [WIDTH-1:0] skid_x;
    logic [WIDTH-1:0] skid_y;
    logic             skid_err;

    ars_sel_mux #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN),
        .IDX_W (IDX_W)
    ) u_mux_x (
        .data(bus.IN_DATA),
        .sel (bus.IN_SEL_X),
        .q   (sel_x),
        .err (err_x)
    );

    ars_sel_mux #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN),
        .IDX_W (IDX_W)
    ) u_mux_y (
        .data(bus.IN_DATA),
        .sel (bus.IN_SEL_Y),
        .q   (sel_y),
        .err (err_y)
    );

    // Mask-XOR exchange keeps the ladder swap free of data-dependent control.
    assign mask    = (sel_x ^ sel_y) & {WIDTH{bus.IN_SWAP}};
    assign new_x   = sel_x ^ mask;
    assign new_y   = sel_y ^ mask;
    assign new_err = err_x | err_y;

    assign accept = bus.IN_VALID & in_ready;
    assign xfer   = (state != EMPTY) & bus.OUT_READY;

    // Occupancy next-state and the register load strobes it implies.
    always_comb begin
        state_n   = state;
        load_in   = 1'b0;
        load_skid = 1'b0;
        load_pop  = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_n = ONE;
                    load_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !xfer) begin
                    state_n   = TWO;
                    load_skid = 1'b1;
                end else if (!accept && xfer) begin
                    state_n = EMPTY;
                end else if (accept && xfer) begin
                    load_in = 1'b1;
                end
            end
            TWO: begin
                if (xfer) begin
                    state_n  = ONE;
                    load_pop = 1'b1;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
    end

    // State and a registered ready so OUT_READY never reaches IN_READY combinationally.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_n;
            in_ready <= (state_n != TWO);
        end
    end

    // Main entry drives the outputs; skid catches the one beat taken while stalled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            main_x   <= '0;
            main_y   <= '0;
            main_err <= 1'b0;
            skid_x   <= '0;
            skid_y   <= '0;
            skid_err <= 1'b0;
        end else begin
            if (load_in) begin
                main_x   <= new_x;
                main_y   <= new_y;
                main_err <= new_err;
            end else if (load_pop) begin
                main_x   <= skid_x;
                main_y   <= skid_y;
                main_err <= skid_err;
            end
            if (load_skid) begin
                skid_x   <= new_x;
                skid_y   <= new_y;
                skid_err <= new_err;
            end
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = (state != EMPTY);
    assign bus.OUT_X     = main_x;
    assign bus.OUT_Y     = main_y;
    assign bus.OUT_ERR   = main_err;

endmodule
